// File: rtl/draw_rect_multi.sv
// draw_rect_multi: overlays up to NUM_RECT solid rectangles on the VGA pixel stream.
// Rectangle settings are copied into shadow registers at each frame start, so objects
// move without tearing. The stage has two register stages: hit test, then priority select.
module draw_rect_multi #(
  parameter int NUM_RECT     = 4,
  parameter int XW           = 12,
  parameter int BLINK_PERIOD = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RECT-1:0]    enable,
  input  logic [NUM_RECT-1:0]    blink,
  input  logic [NUM_RECT*XW-1:0] xpos,
  input  logic [NUM_RECT*XW-1:0] ypos,
  input  logic [NUM_RECT*XW-1:0] rect_w,
  input  logic [NUM_RECT*XW-1:0] rect_h,
  input  logic [NUM_RECT*12-1:0] rect_color,
  input  logic [10:0]            hcount_in,
  input  logic [10:0]            vcount_in,
  input  logic                   hsync_in,
  input  logic                   hblnk_in,
  input  logic                   vsync_in,
  input  logic                   vblnk_in,
  input  logic [11:0]            rgb_in,
  output logic [10:0]            hcount_out,
  output logic [10:0]            vcount_out,
  output logic                   hsync_out,
  output logic                   hblnk_out,
  output logic                   vsync_out,
  output logic                   vblnk_out,
  output logic [11:0]            rgb_out,
  output logic                   hit_valid,
  output logic [2:0]             hit_id,
  output logic                   frame_tick
);

  // Edge arithmetic is one bit wider than the fields, so x+w never wraps.
  localparam int CW = (XW >= 11) ? XW + 1 : 12;
  localparam int FW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  generate
    if (NUM_RECT < 1 || NUM_RECT > 8) begin : g_bad_num_rect
      $error("draw_rect_multi: NUM_RECT must be in 1..8 (hit_id is 3 bits)");
    end
    if (BLINK_PERIOD < 1) begin : g_bad_blink_period
      $error("draw_rect_multi: BLINK_PERIOD must be at least 1");
    end
  endgenerate

  logic frame_start;
  assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

  // ---------------------------------------------------------------- blink timing
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic          blink_phase_reg, blink_phase_next;

  // Next frame count / blink phase; the new phase applies from the frame-start pixel.
  always_comb begin
    frame_cnt_next   = frame_cnt_reg;
    blink_phase_next = blink_phase_reg;
    if (frame_start) begin
      if (frame_cnt_reg == FW'(BLINK_PERIOD - 1)) begin
        frame_cnt_next   = '0;
        blink_phase_next = !blink_phase_reg;
      end else begin
        frame_cnt_next = frame_cnt_reg + 1'b1;
      end
    end
  end

  // Frame counter and blink phase registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      frame_cnt_reg   <= frame_cnt_next;
      blink_phase_reg <= blink_phase_next;
    end
  end

  // ------------------------------------------------------- per-rectangle hit test
  logic [NUM_RECT-1:0] hit_next;
  logic [11:0]         color_next [NUM_RECT];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RECT; gi++) begin : g_rect
      logic          enable_reg, blink_reg;
      logic [XW-1:0] x_reg, y_reg, w_reg, h_reg;
      logic [11:0]   color_reg;

      logic          enable_eff, blink_eff;
      logic [XW-1:0] x_eff, y_eff, w_eff, h_eff;
      logic [11:0]   color_eff;
      logic [CW-1:0] x_last, y_last;
      logic          in_x, in_y, visible;

      // On the frame-start pixel the ports are used directly, so new values
      // take effect on that very pixel.
      assign enable_eff = frame_start ? enable[gi]            : enable_reg;
      assign blink_eff  = frame_start ? blink[gi]             : blink_reg;
      assign x_eff      = frame_start ? xpos[gi*XW +: XW]     : x_reg;
      assign y_eff      = frame_start ? ypos[gi*XW +: XW]     : y_reg;
      assign w_eff      = frame_start ? rect_w[gi*XW +: XW]   : w_reg;
      assign h_eff      = frame_start ? rect_h[gi*XW +: XW]   : h_reg;
      assign color_eff  = frame_start ? rect_color[gi*12 +: 12] : color_reg;

      // Last covered column/row; only meaningful when w/h are non-zero.
      assign x_last = CW'(x_eff) + CW'(w_eff) - CW'(1);
      assign y_last = CW'(y_eff) + CW'(h_eff) - CW'(1);
      assign in_x   = (CW'(hcount_in) >= CW'(x_eff)) && (CW'(hcount_in) <= x_last);
      assign in_y   = (CW'(vcount_in) >= CW'(y_eff)) && (CW'(vcount_in) <= y_last);

      assign visible = enable_eff && !(blink_eff && blink_phase_next) &&
                       (w_eff != '0) && (h_eff != '0);
      // Nothing is drawn during blanking.
      assign hit_next[gi]   = visible && in_x && in_y && !hblnk_in && !vblnk_in;
      assign color_next[gi] = color_eff;

      // Shadow copy of this rectangle's controls, loaded once per frame.
      always_ff @(posedge clk) begin
        if (!rst) begin
          enable_reg <= 1'b0;
          blink_reg  <= 1'b0;
          x_reg      <= '0;
          y_reg      <= '0;
          w_reg      <= '0;
          h_reg      <= '0;
          color_reg  <= '0;
        end else if (frame_start) begin
          enable_reg <= enable[gi];
          blink_reg  <= blink[gi];
          x_reg      <= xpos[gi*XW +: XW];
          y_reg      <= ypos[gi*XW +: XW];
          w_reg      <= rect_w[gi*XW +: XW];
          h_reg      <= rect_h[gi*XW +: XW];
          color_reg  <= rect_color[gi*12 +: 12];
        end
      end
    end
  endgenerate

  // ------------------------------------------------------------------- stage 1
  logic [10:0]         hcount_s1_reg, vcount_s1_reg;
  logic                hsync_s1_reg, hblnk_s1_reg, vsync_s1_reg, vblnk_s1_reg;
  logic [11:0]         rgb_s1_reg;
  logic                tick_s1_reg;
  logic [NUM_RECT-1:0] hit_s1_reg;
  logic [11:0]         color_s1_reg [NUM_RECT];

  // Stage 1: register hit vector, colours in force for this pixel, and timing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcount_s1_reg <= '0;
      vcount_s1_reg <= '0;
      hsync_s1_reg  <= 1'b0;
      hblnk_s1_reg  <= 1'b0;
      vsync_s1_reg  <= 1'b0;
      vblnk_s1_reg  <= 1'b0;
      rgb_s1_reg    <= '0;
      tick_s1_reg   <= 1'b0;
      hit_s1_reg    <= '0;
      for (int i = 0; i < NUM_RECT; i++) color_s1_reg[i] <= '0;
    end else begin
      hcount_s1_reg <= hcount_in;
      vcount_s1_reg <= vcount_in;
      hsync_s1_reg  <= hsync_in;
      hblnk_s1_reg  <= hblnk_in;
      vsync_s1_reg  <= vsync_in;
      vblnk_s1_reg  <= vblnk_in;
      rgb_s1_reg    <= rgb_in;
      tick_s1_reg   <= frame_start;
      hit_s1_reg    <= hit_next;
      for (int i = 0; i < NUM_RECT; i++) color_s1_reg[i] <= color_next[i];
    end
  end

  // ------------------------------------------------------------------- stage 2
  logic        sel_valid;
  logic [2:0]  sel_id;
  logic [11:0] sel_rgb;

  // Priority select: scanning downward leaves the lowest hit index in force.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = 3'd0;
    sel_rgb   = rgb_s1_reg;
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      if (hit_s1_reg[i]) begin
        sel_valid = 1'b1;
        sel_id    = 3'(i);
        sel_rgb   = color_s1_reg[i];
      end
    end
  end

  logic [10:0] hcount_s2_reg, vcount_s2_reg;
  logic        hsync_s2_reg, hblnk_s2_reg, vsync_s2_reg, vblnk_s2_reg;
  logic [11:0] rgb_s2_reg;
  logic        hit_valid_s2_reg, tick_s2_reg;
  logic [2:0]  hit_id_s2_reg;

  // Stage 2: output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcount_s2_reg    <= '0;
      vcount_s2_reg    <= '0;
      hsync_s2_reg     <= 1'b0;
      hblnk_s2_reg     <= 1'b0;
      vsync_s2_reg     <= 1'b0;
      vblnk_s2_reg     <= 1'b0;
      rgb_s2_reg       <= '0;
      hit_valid_s2_reg <= 1'b0;
      hit_id_s2_reg    <= '0;
      tick_s2_reg      <= 1'b0;
    end else begin
      hcount_s2_reg    <= hcount_s1_reg;
      vcount_s2_reg    <= vcount_s1_reg;
      hsync_s2_reg     <= hsync_s1_reg;
      hblnk_s2_reg     <= hblnk_s1_reg;
      vsync_s2_reg     <= vsync_s1_reg;
      vblnk_s2_reg     <= vblnk_s1_reg;
      rgb_s2_reg       <= sel_rgb;
      hit_valid_s2_reg <= sel_valid;
      hit_id_s2_reg    <= sel_id;
      tick_s2_reg      <= tick_s1_reg;
    end
  end

  assign hcount_out = hcount_s2_reg;
  assign vcount_out = vcount_s2_reg;
  assign hsync_out  = hsync_s2_reg;
  assign hblnk_out  = hblnk_s2_reg;
  assign vsync_out  = vsync_s2_reg;
  assign vblnk_out  = vblnk_s2_reg;
  assign rgb_out    = rgb_s2_reg;
  assign hit_valid  = hit_valid_s2_reg;
  assign hit_id     = hit_id_s2_reg;
  assign frame_tick = tick_s2_reg;

endmodule

// File: tb/tb_draw_rect_multi.sv
// Directed testbench for draw_rect_multi: reset, latency, single rect, priority,
// tear-free update, blink, degenerate/off-screen rectangles and blanking.
module tb_draw_rect_multi;
  localparam int NR = 4;
  localparam int XW = 12;
  localparam int BP = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     enable = '0, blink = '0;
  logic [NR*XW-1:0]  xpos = '0, ypos = '0, rect_w = '0, rect_h = '0;
  logic [NR*12-1:0]  rect_color = '0;
  logic [10:0]       hcount_in = '0, vcount_in = '0;
  logic              hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0]       rgb_in = '0;
  logic [10:0]       hcount_out, vcount_out;
  logic              hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0]       rgb_out;
  logic              hit_valid;
  logic [2:0]        hit_id;
  logic              frame_tick;

  int checks = 0;
  int errors = 0;

  draw_rect_multi #(.NUM_RECT(NR), .XW(XW), .BLINK_PERIOD(BP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .blink(blink),
    .xpos(xpos), .ypos(ypos), .rect_w(rect_w), .rect_h(rect_h), .rect_color(rect_color),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .hit_valid(hit_valid), .hit_id(hit_id), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one pixel for exactly one clock edge.
  task automatic step(input logic [10:0] h, input logic [10:0] v,
                      input logic hb, input logic vb, input logic [11:0] bg);
    hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb; rgb_in = bg;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(11'd1000, 11'd700, 1'b1, 1'b1, 12'h000);
  endtask

  // One pixel, then one idle pixel: the output now shows the probed pixel.
  task automatic probe(input string tag, input logic [10:0] h, input logic [10:0] v,
                       input logic hb, input logic vb, input logic [11:0] bg,
                       input logic [11:0] exp_rgb, input logic exp_v, input logic [2:0] exp_id);
    step(h, v, hb, vb, bg);
    idle();
    $display("probe %s (%0d,%0d) rgb=%h hit=%0d id=%0d", tag, h, v, rgb_out, hit_valid, hit_id);
    chk({tag, ".rgb"}, 32'(rgb_out), 32'(exp_rgb));
    chk({tag, ".hit"}, 32'(hit_valid), 32'(exp_v));
    chk({tag, ".id"}, 32'(hit_id), 32'(exp_id));
  endtask

  task automatic frame_start(input string tag);
    step(11'd0, 11'd0, 1'b0, 1'b0, 12'h111);
    idle();
    $display("frame %s tick=%0d", tag, frame_tick);
    chk({tag, ".tick"}, 32'(frame_tick), 32'd1);
    chk({tag, ".h0"}, 32'(hcount_out), 32'd0);
    idle();
    chk({tag, ".tick_off"}, 32'(frame_tick), 32'd0);
  endtask

  task automatic set_rect(input int i, input int x, input int y, input int w, input int h,
                          input logic [11:0] c);
    xpos[i*XW +: XW]     = XW'(x);
    ypos[i*XW +: XW]     = XW'(y);
    rect_w[i*XW +: XW]   = XW'(w);
    rect_h[i*XW +: XW]   = XW'(h);
    rect_color[i*12 +: 12] = c;
  endtask

  initial begin
    // Reset held for 5 clocks while a live stream is driven.
    rst = 1'b0;
    hsync_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(11'(k * 7), (k == 2) ? 11'd0 : 11'd5, 1'b0, 1'b0, 12'hABC);
      $display("reset cycle %0d rgb=%h h=%0d hs=%0d", k, rgb_out, hcount_out, hsync_out);
      chk("rst.rgb", 32'(rgb_out), 32'h0);
      chk("rst.hcount", 32'(hcount_out), 32'h0);
      chk("rst.hsync", 32'(hsync_out), 32'h0);
      chk("rst.tick", 32'(frame_tick), 32'h0);
    end

    // Rect0 configured before release; it must stay invisible until a frame start.
    set_rect(0, 100, 50, 80, 150, 12'h0F0);
    enable = 4'b0001;

    // Release: exactly 2-cycle latency.
    rst = 1'b1;
    hsync_in = 1'b1;
    step(11'd10, 11'd10, 1'b0, 1'b0, 12'h123);
    chk("lat.early", 32'(rgb_out), 32'h0);
    hsync_in = 1'b0;
    step(11'd11, 11'd10, 1'b0, 1'b0, 12'h456);
    $display("latency rgb=%h h=%0d v=%0d hs=%0d", rgb_out, hcount_out, vcount_out, hsync_out);
    chk("lat.rgb", 32'(rgb_out), 32'h123);
    chk("lat.hcount", 32'(hcount_out), 32'd10);
    chk("lat.vcount", 32'(vcount_out), 32'd10);
    chk("lat.hsync", 32'(hsync_out), 32'd1);
    probe("preframe", 11'd120, 11'd60, 1'b0, 1'b0, 12'h321, 12'h321, 1'b0, 3'd0);

    // Frame 1: single rectangle.
    frame_start("f1");
    probe("single.tl",    11'd100, 11'd50,  1'b0, 1'b0, 12'h321, 12'h0F0, 1'b1, 3'd0);
    probe("single.br",    11'd179, 11'd199, 1'b0, 1'b0, 12'h321, 12'h0F0, 1'b1, 3'd0);
    probe("single.left",  11'd99,  11'd50,  1'b0, 1'b0, 12'h321, 12'h321, 1'b0, 3'd0);
    probe("single.right", 11'd180, 11'd50,  1'b0, 1'b0, 12'h322, 12'h322, 1'b0, 3'd0);
    probe("single.below", 11'd100, 11'd200, 1'b0, 1'b0, 12'h323, 12'h323, 1'b0, 3'd0);
    probe("single.hblnk", 11'd120, 11'd60,  1'b1, 1'b0, 12'h324, 12'h324, 1'b0, 3'd0);

    // Tear-free: move rect0 mid-frame; remainder of frame keeps x=100.
    xpos[0 +: XW] = 12'd300;
    step(11'd0, 11'd300, 1'b0, 1'b0, 12'h000);
    probe("tear.old",     11'd120, 11'd100, 1'b0, 1'b0, 12'h055, 12'h0F0, 1'b1, 3'd0);
    probe("tear.new_no",  11'd310, 11'd100, 1'b0, 1'b0, 12'h055, 12'h055, 1'b0, 3'd0);
    frame_start("f2");
    probe("tear.new",     11'd310, 11'd100, 1'b0, 1'b0, 12'h055, 12'h0F0, 1'b1, 3'd0);
    probe("tear.old_no",  11'd120, 11'd100, 1'b0, 1'b0, 12'h055, 12'h055, 1'b0, 3'd0);
    probe("tear.vblnk",   11'd310, 11'd100, 1'b0, 1'b1, 12'h056, 12'h056, 1'b0, 3'd0);

    // Priority: rect0 above rect1.
    set_rect(0, 200, 200, 50, 50, 12'hF00);
    set_rect(1, 220, 220, 50, 50, 12'h00F);
    enable = 4'b0011;
    frame_start("f3");
    probe("prio.overlap", 11'd230, 11'd230, 1'b0, 1'b0, 12'h777, 12'hF00, 1'b1, 3'd0);
    probe("prio.rect1",   11'd260, 11'd260, 1'b0, 1'b0, 12'h777, 12'h00F, 1'b1, 3'd1);
    probe("prio.outside", 11'd265, 11'd215, 1'b0, 1'b0, 12'h778, 12'h778, 1'b0, 3'd0);
    probe("prio.hblnk",   11'd230, 11'd230, 1'b1, 1'b0, 12'h779, 12'h779, 1'b0, 3'd0);

    // Blink and degenerate rectangles: rect0 blinks over rect1; rect2 off the
    // right edge; rect3 has zero width.
    set_rect(0, 100, 50, 80, 150, 12'h0F0);
    set_rect(1, 100, 50, 80, 150, 12'h00F);
    set_rect(2, 4090, 0, 20, 600, 12'hFFF);
    set_rect(3, 0, 0, 0, 100, 12'hAAA);
    enable = 4'b1111;
    blink  = 4'b0001;
    frame_start("f4");
    probe("blink.f4",   11'd120, 11'd60, 1'b0, 1'b0, 12'h246, 12'h0F0, 1'b1, 3'd0);
    probe("nowrap.x5",  11'd5,   11'd10, 1'b0, 1'b0, 12'h246, 12'h246, 1'b0, 3'd0);
    probe("zero_w.x0",  11'd0,   11'd10, 1'b0, 1'b0, 12'h247, 12'h247, 1'b0, 3'd0);
    frame_start("f5");
    probe("blink.f5",   11'd120, 11'd60, 1'b0, 1'b0, 12'h246, 12'h0F0, 1'b1, 3'd0);
    frame_start("f6");
    probe("blink.f6",   11'd120, 11'd60, 1'b0, 1'b0, 12'h246, 12'h00F, 1'b1, 3'd1);
    frame_start("f7");
    probe("blink.f7",   11'd120, 11'd60, 1'b0, 1'b0, 12'h246, 12'h00F, 1'b1, 3'd1);
    frame_start("f8");
    probe("blink.f8",   11'd120, 11'd60, 1'b0, 1'b0, 12'h246, 12'h0F0, 1'b1, 3'd0);

    // Reset mid-frame: outputs clear, then background only until next frame start.
    rst = 1'b0;
    step(11'd120, 11'd60, 1'b0, 1'b0, 12'h777);
    chk("midrst.rgb", 32'(rgb_out), 32'h0);
    chk("midrst.hit", 32'(hit_valid), 32'h0);
    rst = 1'b1;
    probe("midrst.after", 11'd120, 11'd60, 1'b0, 1'b0, 12'h777, 12'h777, 1'b0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
